// File: rtl/id_issue_controller.sv
// Decode-stage issue controller: classifies the IF/ID instruction, drives the immediate SELECT
// code, registers it for EX, inserts one bubble per load-use hazard and counts bubbles.
module id_issue_controller #(
    parameter logic [31:0] NOP_WORD    = 32'h00000013,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    input  logic [31:0]            IN_INSTRUCTION,
    input  logic [31:0]            IN_PC,
    output logic                   IN_READY,
    input  logic                   FLUSH,
    input  logic                   OUT_READY,
    output logic                   OUT_VALID,
    output logic [31:0]            OUT_INSTRUCTION,
    output logic [31:0]            OUT_PC,
    output logic [2:0]             IMM_SEL,
    output logic                   OUT_BUBBLE,
    output logic [COUNT_WIDTH-1:0] BUBBLE_COUNT
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [2:0] SelU    = 3'b000;
    localparam logic [2:0] SelJ    = 3'b001;
    localparam logic [2:0] SelI    = 3'b010;
    localparam logic [2:0] SelB    = 3'b011;
    localparam logic [2:0] SelS    = 3'b100;
    localparam logic [2:0] SelNone = 3'b111;

    typedef enum logic [1:0] {StEmpty, StHold, StHoldLoad} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            pc_q, pc_d;
    logic [2:0]             sel_q, sel_d;
    logic                   bubble_q, bubble_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [4:0]             load_rd_q, load_rd_d;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] in_sel;
    logic       uses_rs1, uses_rs2;
    logic       slot_free, hazard, in_is_load;

    assign opcode = IN_INSTRUCTION[6:0];
    assign rd     = IN_INSTRUCTION[11:7];
    assign rs1    = IN_INSTRUCTION[19:15];
    assign rs2    = IN_INSTRUCTION[24:20];

    always_comb begin
        in_sel   = SelNone;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OpLui, OpAuipc: in_sel = SelU;
            OpJal:          in_sel = SelJ;
            OpJalr, OpLoad, OpImm, OpSystem: begin
                in_sel   = SelI;
                uses_rs1 = 1'b1;
            end
            OpBranch: begin
                in_sel   = SelB;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpStore: begin
                in_sel   = SelS;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OpReg: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_is_load = (opcode == OpLoad) && (rd != 5'd0);
    assign slot_free  = (state_q == StEmpty) || OUT_READY;
    // load_rd_q is only meaningful in StHoldLoad, where it is never x0
    assign hazard     = IN_VALID && (state_q == StHoldLoad) && (load_rd_q != 5'd0) &&
                        ((uses_rs1 && (rs1 == load_rd_q)) || (uses_rs2 && (rs2 == load_rd_q)));
    assign IN_READY   = slot_free && !hazard && !FLUSH && !RESET;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        sel_d     = sel_q;
        bubble_d  = bubble_q;
        count_d   = count_q;
        load_rd_d = load_rd_q;
        if (FLUSH) begin
            state_d = StEmpty;
        end else if (!slot_free) begin
            state_d = state_q;
        end else if (hazard) begin
            state_d  = StHold;
            instr_d  = NOP_WORD;
            pc_d     = IN_PC;
            sel_d    = SelI;
            bubble_d = 1'b1;
            if (!(&count_q)) begin
                count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end else if (IN_VALID) begin
            state_d   = in_is_load ? StHoldLoad : StHold;
            instr_d   = IN_INSTRUCTION;
            pc_d      = IN_PC;
            sel_d     = in_sel;
            bubble_d  = 1'b0;
            load_rd_d = rd;
        end else begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StEmpty;
            instr_q   <= 32'd0;
            pc_q      <= 32'd0;
            sel_q     <= SelNone;
            bubble_q  <= 1'b0;
            count_q   <= '0;
            load_rd_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            sel_q     <= sel_d;
            bubble_q  <= bubble_d;
            count_q   <= count_d;
            load_rd_q <= load_rd_d;
        end
    end

    assign OUT_VALID       = (state_q != StEmpty);
    assign OUT_INSTRUCTION = instr_q;
    assign OUT_PC          = pc_q;
    assign IMM_SEL         = sel_q;
    assign OUT_BUBBLE      = bubble_q;
    assign BUBBLE_COUNT    = count_q;

endmodule
